// File: rtl/mtc_channel_allocator_if.sv
// Candidate/grant bundle between the SL candidate source and the pT-calc channel allocator.
// master drives requests and channel completions; slave is the allocator.
interface mtc_channel_allocator_if #(
    parameter int N_CH = 3,
    parameter int N_IN = 3,
    parameter int CH_W = $clog2(N_CH)
);
    logic [N_IN-1:0]           slc_valid;
    logic [N_CH-1:0]           ch_done;
    logic [N_IN-1:0]           assign_valid;
    logic [N_IN-1:0][CH_W-1:0] assign_ch;
    logic [N_IN-1:0]           assign_busy;
    logic [N_CH-1:0]           ch_alloc;
    logic [N_CH-1:0]           timeout_err;
    logic [N_CH-1:0]           spurious_done;
    logic [15:0]               refused_cnt;

    modport master (
        output slc_valid, ch_done,
        input  assign_valid, assign_ch, assign_busy, ch_alloc,
               timeout_err, spurious_done, refused_cnt
    );

    modport slave (
        input  slc_valid, ch_done,
        output assign_valid, assign_ch, assign_busy, ch_alloc,
               timeout_err, spurious_done, refused_cnt
    );
endinterface

// File: rtl/mtc_channel_allocator.sv
// Allocates SL candidates to shared pT-calc channels, searching round-robin from rr_ptr.
// Each channel is released by ch_done, or by its age counter if the result never arrives.
//
// state   | meaning
// CH_FREE | channel idle, may be granted to a candidate
// CH_BUSY | channel processing a candidate, age counting towards TIMEOUT
module mtc_channel_allocator #(
    parameter int N_CH    = 3,
    parameter int N_IN    = 3,
    parameter int TIMEOUT = 64,
    parameter int CH_W    = $clog2(N_CH)
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   srst,
    mtc_channel_allocator_if.slave bus
);
    typedef enum logic {CH_FREE = 1'b0, CH_BUSY = 1'b1} ch_state_e;

    ch_state_e                 ch_state_q [N_CH];
    ch_state_e                 ch_state_d [N_CH];
    logic [15:0]               age_q [N_CH];
    logic [15:0]               age_d [N_CH];
    logic [CH_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [15:0]               refused_cnt_q, refused_cnt_d;
    logic [N_IN-1:0]           assign_valid_q, assign_valid_d;
    logic [N_IN-1:0]           assign_busy_q, assign_busy_d;
    logic [N_IN-1:0][CH_W-1:0] assign_ch_q, assign_ch_d;
    logic [N_CH-1:0]           timeout_err_q, timeout_err_d;
    logic [N_CH-1:0]           spurious_done_q, spurious_done_d;

    logic [N_CH-1:0]           busy_now;
    logic [N_CH-1:0]           taken;
    logic [N_CH-1:0]           granted;
    logic [CH_W-1:0]           idx;
    logic [CH_W-1:0]           sel;
    logic [CH_W-1:0]           last_ch;
    logic                      found;
    logic                      any_grant;
    logic [15:0]               n_refused;
    logic [16:0]               refused_sum;

    function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_CH) s = s - N_CH;
        return CH_W'(s);
    endfunction

    // Search sees only channels FREE at the start of the cycle, so a same-cycle ch_done
    // cannot be reused before the next sampled request.
    always_comb begin
        for (int c = 0; c < N_CH; c++) busy_now[c] = (ch_state_q[c] == CH_BUSY);
        taken          = busy_now;
        granted        = '0;
        any_grant      = 1'b0;
        last_ch        = '0;
        n_refused      = '0;
        idx            = '0;
        sel            = '0;
        found          = 1'b0;
        assign_valid_d = '0;
        assign_busy_d  = '0;
        assign_ch_d    = '0;
        for (int i = 0; i < N_IN; i++) begin
            found = 1'b0;
            sel   = '0;
            if (bus.slc_valid[i]) begin
                for (int k = 0; k < N_CH; k++) begin
                    idx = wrap_idx(rr_ptr_q, k);
                    if (!found && !taken[idx]) begin
                        found = 1'b1;
                        sel   = idx;
                    end
                end
                assign_valid_d[i] = 1'b1;
                if (found) begin
                    taken[sel]     = 1'b1;
                    granted[sel]   = 1'b1;
                    assign_ch_d[i] = sel;
                    any_grant      = 1'b1;
                    last_ch        = sel;
                end else begin
                    assign_busy_d[i] = 1'b1;
                    n_refused        = n_refused + 16'd1;
                end
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (any_grant) rr_ptr_d = (last_ch == CH_W'(N_CH - 1)) ? '0 : last_ch + CH_W'(1);
        refused_sum   = {1'b0, refused_cnt_q} + {1'b0, n_refused};
        refused_cnt_d = refused_sum[16] ? 16'hFFFF : refused_sum[15:0];
    end

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            ch_state_d[c]      = ch_state_q[c];
            age_d[c]           = age_q[c];
            timeout_err_d[c]   = 1'b0;
            spurious_done_d[c] = 1'b0;
            case (ch_state_q[c])
                CH_BUSY: begin
                    if (bus.ch_done[c]) begin
                        ch_state_d[c] = CH_FREE;
                        age_d[c]      = '0;
                    end else if (age_q[c] == 16'(TIMEOUT - 1)) begin
                        ch_state_d[c]    = CH_FREE;
                        age_d[c]         = '0;
                        timeout_err_d[c] = 1'b1;
                    end else begin
                        age_d[c] = age_q[c] + 16'd1;
                    end
                end
                default: begin
                    spurious_done_d[c] = bus.ch_done[c];
                    if (granted[c]) begin
                        ch_state_d[c] = CH_BUSY;
                        age_d[c]      = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (rst || srst) begin
            for (int c = 0; c < N_CH; c++) begin
                ch_state_q[c] <= CH_FREE;
                age_q[c]      <= '0;
            end
            rr_ptr_q        <= '0;
            refused_cnt_q   <= '0;
            assign_valid_q  <= '0;
            assign_busy_q   <= '0;
            assign_ch_q     <= '0;
            timeout_err_q   <= '0;
            spurious_done_q <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                ch_state_q[c] <= ch_state_d[c];
                age_q[c]      <= age_d[c];
            end
            rr_ptr_q        <= rr_ptr_d;
            refused_cnt_q   <= refused_cnt_d;
            assign_valid_q  <= assign_valid_d;
            assign_busy_q   <= assign_busy_d;
            assign_ch_q     <= assign_ch_d;
            timeout_err_q   <= timeout_err_d;
            spurious_done_q <= spurious_done_d;
        end
    end

    assign bus.assign_valid  = assign_valid_q;
    assign bus.assign_busy   = assign_busy_q;
    assign bus.assign_ch     = assign_ch_q;
    assign bus.ch_alloc      = busy_now;
    assign bus.timeout_err   = timeout_err_q;
    assign bus.spurious_done = spurious_done_q;
    assign bus.refused_cnt   = refused_cnt_q;
endmodule

// File: tb/tb_mtc_channel_allocator.sv
// Directed bench for mtc_channel_allocator: vector table plus timeout, reset and saturation sequences.
module tb_mtc_channel_allocator;
    localparam int N_CH    = 3;
    localparam int N_IN    = 3;
    localparam int TIMEOUT = 64;
    localparam int CH_W    = 2;

    logic clock = 1'b0;
    logic rst;
    logic srst;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clock = ~clock;

    mtc_channel_allocator_if #(.N_CH(N_CH), .N_IN(N_IN), .CH_W(CH_W)) bus ();

    mtc_channel_allocator #(.N_CH(N_CH), .N_IN(N_IN), .TIMEOUT(TIMEOUT), .CH_W(CH_W)) dut (
        .clock(clock),
        .rst  (rst),
        .srst (srst),
        .bus  (bus)
    );

    typedef struct {
        logic [2:0]  slc;
        logic [2:0]  done;
        logic [2:0]  valid;
        logic [2:0]  busy;
        logic [5:0]  ch;
        logic [2:0]  alloc;
        logic [2:0]  to;
        logic [2:0]  spur;
        logic [15:0] refd;
    } vec_t;

    vec_t vecs [19];

    // {valid, busy, ch[2:0], alloc, timeout_err, spurious_done, refused_cnt}
    function automatic logic [36:0] obs();
        return {bus.assign_valid, bus.assign_busy, bus.assign_ch, bus.ch_alloc,
                bus.timeout_err, bus.spurious_done, bus.refused_cnt};
    endfunction

    function automatic logic [36:0] pack(input logic [2:0] valid, busy, input logic [5:0] ch,
                                         input logic [2:0] alloc, to, spur, input logic [15:0] refd);
        return {valid, busy, ch, alloc, to, spur, refd};
    endfunction

    task automatic check(input string name, input logic [36:0] got, input logic [36:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input logic [2:0] s, input logic [2:0] d);
        bus.slc_valid = s;
        bus.ch_done   = d;
        @(posedge clock);
        #1;
    endtask

    initial begin
        //           slc     done    valid   busy    ch          alloc   to      spur    refd
        vecs[0]  = '{3'b111, 3'b000, 3'b111, 3'b000, 6'b100100, 3'b111, 3'b000, 3'b000, 16'd0};
        vecs[1]  = '{3'b011, 3'b000, 3'b011, 3'b011, 6'b000000, 3'b111, 3'b000, 3'b000, 16'd2};
        vecs[2]  = '{3'b000, 3'b010, 3'b000, 3'b000, 6'b000000, 3'b101, 3'b000, 3'b000, 16'd2};
        vecs[3]  = '{3'b001, 3'b000, 3'b001, 3'b000, 6'b000001, 3'b111, 3'b000, 3'b000, 16'd2};
        vecs[4]  = '{3'b000, 3'b101, 3'b000, 3'b000, 6'b000000, 3'b010, 3'b000, 3'b000, 16'd2};
        vecs[5]  = '{3'b011, 3'b000, 3'b011, 3'b000, 6'b000010, 3'b111, 3'b000, 3'b000, 16'd2};
        vecs[6]  = '{3'b000, 3'b011, 3'b000, 3'b000, 6'b000000, 3'b100, 3'b000, 3'b000, 16'd2};
        vecs[7]  = '{3'b001, 3'b000, 3'b001, 3'b000, 6'b000001, 3'b110, 3'b000, 3'b000, 16'd2};
        vecs[8]  = '{3'b110, 3'b000, 3'b110, 3'b100, 6'b000000, 3'b111, 3'b000, 3'b000, 16'd3};
        vecs[9]  = '{3'b001, 3'b001, 3'b001, 3'b001, 6'b000000, 3'b110, 3'b000, 3'b000, 16'd4};
        vecs[10] = '{3'b001, 3'b000, 3'b001, 3'b000, 6'b000000, 3'b111, 3'b000, 3'b000, 16'd4};
        vecs[11] = '{3'b000, 3'b100, 3'b000, 3'b000, 6'b000000, 3'b011, 3'b000, 3'b000, 16'd4};
        vecs[12] = '{3'b000, 3'b100, 3'b000, 3'b000, 6'b000000, 3'b011, 3'b000, 3'b100, 16'd4};
        vecs[13] = '{3'b000, 3'b000, 3'b000, 3'b000, 6'b000000, 3'b011, 3'b000, 3'b000, 16'd4};
        vecs[14] = '{3'b100, 3'b000, 3'b100, 3'b000, 6'b100000, 3'b111, 3'b000, 3'b000, 16'd4};
        vecs[15] = '{3'b111, 3'b111, 3'b111, 3'b111, 6'b000000, 3'b000, 3'b000, 3'b000, 16'd7};
        vecs[16] = '{3'b010, 3'b001, 3'b010, 3'b000, 6'b000000, 3'b001, 3'b000, 3'b001, 16'd7};
        vecs[17] = '{3'b101, 3'b000, 3'b101, 3'b000, 6'b100001, 3'b111, 3'b000, 3'b000, 16'd7};
        vecs[18] = '{3'b000, 3'b111, 3'b000, 3'b000, 6'b000000, 3'b000, 3'b000, 3'b000, 16'd7};

        rst           = 1'b1;
        srst          = 1'b0;
        bus.slc_valid = '0;
        bus.ch_done   = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset", obs(), '0);
        rst = 1'b0;

        for (int v = 0; v < 19; v++) begin
            step(vecs[v].slc, vecs[v].done);
            check($sformatf("vec%0d", v), obs(),
                  pack(vecs[v].valid, vecs[v].busy, vecs[v].ch, vecs[v].alloc,
                       vecs[v].to, vecs[v].spur, vecs[v].refd));
        end

        // channel 1 left running until it times out; channel 0 completes normally
        step(3'b011, 3'b000);
        check("to_grant", obs(), pack(3'b011, 3'b000, 6'b000100, 3'b011, 3'b000, 3'b000, 16'd7));
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            step(3'b000, (k == 1) ? 3'b001 : 3'b000);
            check($sformatf("to_wait%0d", k), obs(),
                  pack(3'b000, 3'b000, 6'b000000, (k < TIMEOUT) ? 3'b010 : 3'b000,
                       (k == TIMEOUT) ? 3'b010 : 3'b000, 3'b000, 16'd7));
        end

        // ch_done lands on the cycle the timeout would fire
        step(3'b001, 3'b000);
        check("coin_grant", obs(), pack(3'b001, 3'b000, 6'b000010, 3'b100, 3'b000, 3'b000, 16'd7));
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            step(3'b000, (k == TIMEOUT) ? 3'b100 : 3'b000);
            check($sformatf("coin_wait%0d", k), obs(),
                  pack(3'b000, 3'b000, 6'b000000, (k < TIMEOUT) ? 3'b100 : 3'b000,
                       3'b000, 3'b000, 16'd7));
        end

        // reset mid-allocation; requests during reset ignored; late ch_done is spurious
        step(3'b111, 3'b000);
        check("rst_grant", obs(), pack(3'b111, 3'b000, 6'b100100, 3'b111, 3'b000, 3'b000, 16'd7));
        rst = 1'b1;
        step(3'b111, 3'b000);
        check("rst_clear", obs(), '0);
        rst = 1'b0;
        step(3'b000, 3'b111);
        check("rst_spur", obs(), pack(3'b000, 3'b000, 6'b000000, 3'b000, 3'b000, 3'b111, 16'd0));
        step(3'b000, 3'b000);
        check("rst_idle", obs(), '0);

        // continuous requests drive refused_cnt into saturation
        repeat (25000) step(3'b111, 3'b000);
        check("sat_reach", {21'd0, bus.refused_cnt}, 37'h0FFFF);
        repeat (200) step(3'b111, 3'b000);
        check("sat_hold", {21'd0, bus.refused_cnt}, 37'h0FFFF);

        srst = 1'b1;
        step(3'b111, 3'b000);
        check("srst_clear", obs(), '0);
        srst = 1'b0;
        step(3'b111, 3'b000);
        check("srst_regrant", obs(), pack(3'b111, 3'b000, 6'b100100, 3'b111, 3'b000, 3'b000, 16'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
